// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one fixed-latency, single-port unified memory between the IF stage
// (instruction fetch) and the MEM stage (load/store). Each transaction is
// issued as a single registered command cycle on ram_*. The winning stage
// gets a one-cycle ready pulse MEM_LAT cycles after that command cycle.
// Per-stage stall signals are produced for the hazard logic.
//
// Parameters:
//   ADDR_W   address width of both requesters and the memory port
//   DATA_W   data width
//   MEM_LAT  cycles from the ram_en cycle to ram_rdata valid (>= 1)
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   if_req, if_addr       fetch request (level) and fetch address
//   if_rdata, if_ready    fetched instruction and one-cycle completion pulse
//   mem_rd, mem_wr        load / store request (level); both set => store
//   mem_addr, mem_wdata   data address and store data
//   mem_rdata, mem_ready  load data and one-cycle completion pulse
//   stall_if, stall_mem   request pending and not completing this cycle
//   ram_en, ram_we        registered memory command strobe / write enable
//   ram_addr, ram_wdata   registered memory address / write data
//   ram_rdata             memory read data
//
// Optional build macro ARB_PERF_CNT_EN adds perf_if_stall_cnt and
// perf_mem_stall_cnt, which are saturating 32-bit counts of the stall cycles.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_stall_cnt,
    output logic [31:0]       perf_mem_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_MEM
    } owner_t;

    state_t           state;
    owner_t           owner;
    logic [CNT_W-1:0] counter;

    logic mem_req;
    logic done;
    logic issue_mem;
    logic issue_if;

    // The completion cycle is the one where the down-counter has reached zero.
    // The ready pulses are decoded from registered state only, so reset clears
    // them immediately and a late ram_rdata can never surface afterwards.
    assign mem_req   = mem_rd | mem_wr;
    assign done      = (state == ST_BUSY) && (counter == '0);
    assign if_ready  = done && (owner == OWN_IF);
    assign mem_ready = done && (owner == OWN_MEM);
    assign if_rdata  = if_ready  ? ram_rdata : '0;
    assign mem_rdata = mem_ready ? ram_rdata : '0;
    assign stall_if  = if_req  & ~if_ready;
    assign stall_mem = mem_req & ~mem_ready;

    // Issue decision. From IDLE, a data request beats a fetch because it
    // belongs to the older instruction. In the completion cycle only the
    // *other* requester may be issued. The finishing owner still holds its
    // request and must not be re-issued. This hand-over bounds how long a
    // fetch can wait to one data transaction.
    always_comb begin
        issue_mem = 1'b0;
        issue_if  = 1'b0;
        if (state == ST_IDLE) begin
            issue_mem = mem_req;
            issue_if  = if_req & ~mem_req;
        end else if (done) begin
            issue_mem = (owner == OWN_IF)  && mem_req;
            issue_if  = (owner == OWN_MEM) && if_req;
        end
    end

    // Transaction sequencer. Address and write data hold between commands.
    // The strobe and write enable are single-cycle pulses. A store wins over a
    // load when both are raised together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner     <= OWN_NONE;
            counter   <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            if (issue_mem) begin
                ram_en    <= 1'b1;
                ram_we    <= mem_wr;
                ram_addr  <= mem_addr;
                ram_wdata <= mem_wdata;
                state     <= ST_BUSY;
                owner     <= OWN_MEM;
                counter   <= CNT_LOAD;
            end else if (issue_if) begin
                ram_en    <= 1'b1;
                ram_addr  <= if_addr;
                state     <= ST_BUSY;
                owner     <= OWN_IF;
                counter   <= CNT_LOAD;
            end else if (state == ST_BUSY) begin
                if (counter != '0) begin
                    counter <= counter - 1'b1;
                end else begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                end
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    // Stall-cycle counters. They stick at all-ones rather than wrapping, so
    // that a long run never reports a misleadingly small number.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_stall_cnt  <= '0;
            perf_mem_stall_cnt <= '0;
        end else begin
            if (stall_if && (perf_if_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_if_stall_cnt <= perf_if_stall_cnt + 32'd1;
            end
            if (stall_mem && (perf_mem_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_mem_stall_cnt <= perf_mem_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one fixed-latency single-port unified memory between the pipeline's IF stage (instruction fetch) and MEM stage (load/store).
- Sequences each transaction and returns a one-cycle ready pulse to the winning stage.
- Generates the per-stage stall signals that the hazard logic uses to freeze the pipeline.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the memory-port command cycle to ram_rdata valid. Must be ≥1.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; level, held until if_ready.
- if_addr  in  ADDR_W  fetch address (IF_PC).
- if_rdata  out  DATA_W  fetched instruction; valid only while if_ready=1.
- if_ready  out  1  one-cycle fetch-complete pulse.
- mem_rd  in  1  load request; level, held until mem_ready.
- mem_wr  in  1  store request; level, held until mem_ready.
- mem_addr  in  ADDR_W  data address (MEM_aluresult).
- mem_wdata  in  DATA_W  store data (MEM_readda2).
- mem_rdata  out  DATA_W  load data; valid only while mem_ready=1.
- mem_ready  out  1  one-cycle data-complete pulse.
- stall_if  out  1  if_req & ~if_ready.
- stall_mem  out  1  (mem_rd|mem_wr) & ~mem_ready.
- ram_en  out  1  memory command strobe, registered.
- ram_we  out  1  memory write enable, registered.
- ram_addr  out  ADDR_W  memory address, registered.
- ram_wdata  out  DATA_W  memory write data, registered.
- ram_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the ram_en cycle.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values:
  - state=IDLE, owner=NONE, counter=0.
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - if_ready=0, mem_ready=0. if_rdata and mem_rdata are driven 0 when not ready.
  - stall_if and stall_mem follow their combinational equations, i.e. they equal the raw request during reset.
- States:
  - IDLE.
  - BUSY: owner ∈ {IF, MEM}, counter width $clog2(MEM_LAT+1).
- Issue:
  - In IDLE, a request seen in cycle t is registered onto ram_* for cycle t+1 only; ram_en=1 for exactly one cycle.
  - The FSM enters BUSY with counter=MEM_LAT in cycle t+1.
- Priority in IDLE: when a data request and if_req are present together, MEM wins (older instruction).
- Read/write conflict: if mem_rd and mem_wr are both 1, the transaction is a write (ram_we=1) and mem_rd is ignored.
- BUSY:
  - counter decrements each cycle.
  - When counter==0, in cycle t+1+MEM_LAT, the owner's ready pulses for one cycle.
  - In that same cycle the owner's rdata = ram_rdata (combinational pass-through). For writes, rdata is don't-care but the ready pulse is still produced.
  - Request-to-ready latency is MEM_LAT+1 cycles.
- Completion cycle:
  - The completing owner's request is still asserted and must NOT be re-issued.
  - If the other requester is pending, it is issued: ram_* loaded for the next cycle, owner switches, counter=MEM_LAT.
  - Otherwise the FSM returns to IDLE.
  - This guarantees a fetch waits behind at most one data transaction, so there is no starvation.
- Requests arriving while BUSY for the other owner wait; their stall stays 1.
- A request deasserted before its ready (illegal in normal operation): the in-flight transaction still completes and the ready pulse is still generated.
- Reset mid-operation: the in-flight transaction is abandoned and no ready pulse occurs after reset release. A late ram_rdata is ignored.
- ram_* hold their last values while ram_en=0, except ram_we, which is 0 whenever ram_en=0.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds ports perf_if_stall_cnt out 32 and perf_mem_stall_cnt out 32.
  - Each counts cycles with stall_if=1 / stall_mem=1 respectively.
  - Counters saturate at 0xFFFFFFFF and reset to 0 on rst_n.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan (all with MEM_LAT=2):
- Fetch only: if_req=1, if_addr=0x00000004 from cycle 0; ram_rdata=0x20080005 in cycle 3.
  - Cycle 1: ram_en=1, ram_we=0, ram_addr=0x4.
  - Cycle 3: if_ready=1, if_rdata=0x20080005.
  - stall_if=1 in cycles 0–2 and 0 in cycle 3.
- Simultaneous requests: if_req with if_addr=0x8, plus mem_rd with mem_addr=0x100, both at cycle 0.
  - Cycle 1: ram_addr=0x100.
  - Cycle 3: mem_ready.
  - Cycle 4: ram_addr=0x8.
  - Cycle 6: if_ready.
  - No ram_en in cycles 2–3.
- Store: mem_wr, mem_addr=0x8, mem_wdata=0xDEADBEEF.
  - Cycle 1: ram_en=1, ram_we=1, ram_wdata=0xDEADBEEF.
  - Cycle 3: mem_ready=1.
  - Cycle 2: ram_we=0.
- Read/write conflict: mem_rd=mem_wr=1 → ram_we=1 on the issue cycle.
- Reset mid-operation: a fetch is issued at cycle 0 and rst_n=0 during cycle 2.
  - All ram_*, if_ready and mem_ready go to 0 immediately.
  - After release with if_req=0, no if_ready ever pulses.
- With ARB_PERF_CNT_EN defined, after the simultaneous-request scenario: perf_if_stall_cnt=6, perf_mem_stall_cnt=3.
